// File: rtl/match_event_logger_if.sv
// Event-logger port bundle: match input, stats clear, show-ahead event
// output with valid/ready, and the registered status/statistics.
interface match_event_logger_if #(
   parameter int TS_W  = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic            match_in;
   logic            ev_ready;
   logic            clr_stats;
   logic            ev_valid;
   logic [TS_W-1:0] ev_ts;
   logic [LW-1:0]   fifo_level;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic            overflow;

   // The logger is the master: it produces events and status
   modport master (
      input  match_in, ev_ready, clr_stats,
      output ev_valid, ev_ts, fifo_level, match_cnt, drop_cnt, overflow
   );

   modport slave (
      output match_in, ev_ready, clr_stats,
      input  ev_valid, ev_ts, fifo_level, match_cnt, drop_cnt, overflow
   );
endinterface

// File: rtl/match_event_logger.sv
// Timestamps sampled detector matches into a show-ahead FIFO drained by
// valid/ready, with saturating match/drop counters and a sticky overflow.
module match_event_logger #(
   parameter int TS_W  = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   match_event_logger_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [TS_W-1:0]  ts;
   logic [TS_W-1:0]  mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [LW-1:0]    level;
   logic [CNT_W-1:0] match_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic             overflow;

   logic empty;
   logic full;
   logic pop;
   logic push;
   logic drop;

   // A pop frees a slot before the push lands, so full+pop+push never drops
   always_comb begin
      empty = (level == '0);
      full  = (level == LW'(DEPTH));
      pop   = !empty && bus.ev_ready;
      push  = bus.match_in && (!full || pop);
      drop  = bus.match_in && full && !pop;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ts <= '0;
      end else begin
         ts <= ts + TS_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= ts;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Clear wins over any increment; the FIFO side is unaffected by it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else if (bus.clr_stats) begin
         match_cnt <= '0;
         drop_cnt  <= '0;
         overflow  <= 1'b0;
      end else begin
         if (bus.match_in && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
         end
         if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   assign bus.ev_valid   = !empty;
   assign bus.ev_ts      = empty ? '0 : mem[rd_ptr];
   assign bus.fifo_level = level;
   assign bus.match_cnt  = match_cnt;
   assign bus.drop_cnt   = drop_cnt;
   assign bus.overflow   = overflow;
endmodule

// File: doc/match_event_logger.md
# match_event_logger

Downstream consumer of the 1010 sequence detector's `data_out` match pulse. Each sampled match is timestamped with a free-running cycle counter and queued in a small show-ahead FIFO drained through a valid/ready port. The block also keeps saturating match and drop statistics. It lets a slower host or monitor collect detection events without losing ordering.

## Interface
Parameters:
- `TS_W`, 16, timestamp/cycle-counter width.
- `DEPTH`, 4, FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, 8, width of the `match_cnt` and `drop_cnt` statistics counters.

Ports:
- `clk`  input  1  single clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-low reset; clears all state immediately.
- `match_in`  input  1  match pulse from the detector's `data_out`; sampled only at the rising edge of `clk`.
- `ev_ready`  input  1  consumer ready to accept the head event.
- `clr_stats`  input  1  synchronous clear of `match_cnt`, `drop_cnt` and `overflow`.
- `ev_valid`  output  1  FIFO not empty; head event presented.
- `ev_ts`  output  TS_W  timestamp of the head event; 0 when empty.
- `fifo_level`  output  $clog2(DEPTH)+1  number of stored events.
- `match_cnt`  output  CNT_W  total sampled matches; saturates at all-ones.
- `drop_cnt`  output  CNT_W  matches lost to a full FIFO; saturates at all-ones.
- `overflow`  output  1  sticky flag, set on the first drop.

## Operation
- **Reset values.** While `rst` is low, every output reads 0: `ev_valid`, `ev_ts`, `fifo_level`, `match_cnt`, `drop_cnt` and `overflow`. The internal timestamp `ts` and the read/write pointers are also 0.
- **Timestamp.**
  - `ts` increments by 1 on every clock edge after reset is released.
  - It wraps modulo 2^TS_W with no flag.
  - A match sampled at an edge records the value `ts` held before that edge. The first edge after reset therefore records 0.
- **Push.** A push is requested on every edge where `match_in` = 1.
- **Pop.** A pop occurs on every edge where `ev_valid` && `ev_ready`. `ev_ready` is ignored when the FIFO is empty.
- **Push, not full.** The event is written at the tail, and `fifo_level` increments.
- **Push while full, no pop.** The event is dropped; the FIFO contents are unchanged. `drop_cnt` increments (saturating) and `overflow` is set.
- **Push and pop together.**
  - The pop is performed first, so a push while full succeeds and nothing is dropped.
  - `fifo_level` is unchanged.
  - When the FIFO is empty, only the push takes effect.
- **Pop only.** The head advances, and `fifo_level` decrements.
- **Match counting.** `match_cnt` increments (saturating) on every sampled match, including dropped ones.
- **Statistics clear.** `clr_stats` = 1 at an edge sets `match_cnt`, `drop_cnt` and `overflow` to 0.
  - The clear has priority over any increment at the same edge.
  - A concurrent match is still pushed or dropped in the FIFO, but is not counted.
  - The FIFO and `ts` are unaffected.
- **Pointers.** Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are derived from `fifo_level`.
- **Ordering.** Events leave the FIFO in strict arrival order.

## Timing
- **Push latency.** A match sampled at edge k gives `ev_valid` = 1 and `ev_ts` = the stamp from edge k+1 onward, if the FIFO was empty.
- **Show-ahead output.** `ev_ts` is driven combinationally from the head entry. It is stable while `ev_valid` && !`ev_ready`.
- **Valid persistence.** Once asserted, `ev_valid` stays high until the head is popped.
- **Back-to-back throughput.** Pushing one event per cycle and popping one event per cycle is sustained indefinitely with no drops.
- **Input sampling.** `match_in` may glitch between edges, because the detector output is combinational. Only the value at the rising edge matters.
- **Reset mid-operation.** Asserting `rst` asynchronously flushes the FIFO and all counters. Outputs go to 0 without waiting for a clock edge.
- **Status updates.** `fifo_level`, `match_cnt`, `drop_cnt` and `overflow` are registered; they reflect the edge just taken.

## Test plan
- **Reset.** Hold `rst` = 0 with random `match_in`/`ev_ready` -> all outputs 0. Release `rst` and pulse `match_in` at the 1st edge -> `ev_ts` = 0, `ev_valid` = 1.
- **Single event.** `ev_ready` = 0, pulse at the edge where `ts` = 5 -> next cycle `ev_valid` = 1, `ev_ts` = 5, `fifo_level` = 1, `match_cnt` = 1. Raise `ev_ready` for one cycle -> `ev_valid` = 0, `fifo_level` = 0.
- **Overflow (DEPTH=4).** `ev_ready` = 0, pulses at `ts` 10, 12, 14, 16, 18 (overlapping-1010 spacing) -> `fifo_level` = 4, `drop_cnt` = 1, `overflow` = 1, `match_cnt` = 5. Drain -> `ev_ts` sequence 10, 12, 14, 16.
- **Full with push and pop together.** Fill to 4, then push with `ev_ready` = 1 at the same edge -> no drop, `fifo_level` stays 4, new event appears last in drain order.
- **Timestamp wrap (TS_W=4).** Pulse at the 18th edge after reset -> `ev_ts` = 1. Saturation (CNT_W=2): 5 matches -> `match_cnt` = 3.
- **Clear and reset priority.** `clr_stats` with a simultaneous match -> counters 0, event still queued. Assert `rst` with 3 queued events -> immediately `ev_valid` = 0, `fifo_level` = 0.
